// File: rtl/uart_pkg.sv
// Shared definitions for the UART word transmitter and its baud-rate helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    localparam int BAUD_115K2_133M = 1157;
    localparam int BAUD_CNT_W      = 11;

    // Start bit + 8 data bits + stop bits.
    function automatic int frame_bits(input int stop_bits);
        return 9 + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with synchronous clear; tick marks the last clock of a bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_115K2_133M
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam logic [BAUD_CNT_W-1:0] TERM_CNT = BAUD_CNT_W'(BAUD_DIV - 1);

    logic [BAUD_CNT_W-1:0] baud_cnt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            baud_cnt <= '0;
        end else if (clear || (baud_cnt == TERM_CNT)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = (baud_cnt == TERM_CNT) && !clear;

endmodule

// File: rtl/uart_word_txmod.sv
// Sends one NBYTES-wide word as back-to-back UART frames, most significant byte first.
//
//   state | meaning
//   IDLE  | line high, waiting for iCall; word latched on request
//   LOAD  | one cycle to clear the bit/byte/baud counters
//   SHIFT | frames on TXD; TXD is registered one clock behind the counters
//   DONE  | oDone pulse, line high, back to IDLE
module uart_word_txmod
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = BAUD_115K2_133M,
    parameter int NBYTES    = 8,
    parameter int STOP_BITS = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  iCall,
    output logic                  oDone,
    input  logic [NBYTES*8-1:0]   iData,
    output logic                  oBusy,
    output logic                  TXD
);

    localparam int         W         = NBYTES * 8;
    localparam logic [3:0] LAST_BIT  = 4'(frame_bits(STOP_BITS) - 1);
    localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

    tx_state_e      state;
    logic [W-1:0]   shreg;
    logic [3:0]     bit_idx;
    logic [2:0]     byte_idx;
    logic           last_q;
    logic           tick;
    logic [7:0]     cur_byte;
    logic [2:0]     data_sel;
    logic           frame_bit;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clear (state != SHIFT),
        .tick  (tick)
    );

    assign cur_byte = shreg[W-1 -: 8];

    always_comb begin
        data_sel  = 3'(bit_idx - 4'd1);
        frame_bit = 1'b1;
        if (bit_idx == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_idx <= 4'd8) begin
            frame_bit = cur_byte[data_sel];
        end
    end

    // last_q holds SHIFT for one extra clock so the final stop bit, which
    // lags the counters by a cycle on TXD, is complete when DONE is entered.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            last_q   <= 1'b0;
            TXD      <= 1'b1;
            oDone    <= 1'b0;
            oBusy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    TXD   <= 1'b1;
                    if (iCall) begin
                        shreg <= iData;
                        oBusy <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    last_q   <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (last_q) begin
                        last_q <= 1'b0;
                        TXD    <= 1'b1;
                        oDone  <= 1'b1;
                        oBusy  <= 1'b0;
                        state  <= DONE;
                    end else begin
                        TXD <= frame_bit;
                        if (tick) begin
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                if (byte_idx == LAST_BYTE) begin
                                    last_q <= 1'b1;
                                end else begin
                                    byte_idx <= byte_idx + 3'd1;
                                    shreg    <= shreg << 8;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    TXD   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_txmod.sv
// Scoreboard bench: expected bytes queued at request time, compared as frames are decoded from TXD.
module tb_uart_word_txmod;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic [4:0]  rst_v = 5'h1F;
    logic [4:0]  call_v = 5'h00;
    wire  [4:0]  done_v, busy_v, txd_v;
    logic [63:0] d0 = '0;
    logic [7:0]  d1 = '0;
    logic [15:0] d2 = '0;
    logic [15:0] d3 = '0;
    logic [7:0]  d4 = '0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cnt [5] = '{default: 0};
    logic [7:0] exp_q [$];
    logic [2:0] sel = 3'd0;
    wire txd_m;
    assign txd_m = txd_v[sel];

    always @(posedge CLOCK) cyc <= cyc + 1;
    always @(posedge CLOCK)
        for (int i = 0; i < 5; i++)
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;

    uart_word_txmod #(.BAUD_DIV(4), .NBYTES(8), .STOP_BITS(2)) u0 (
        .CLOCK(CLOCK), .RESET(rst_v[0]), .iCall(call_v[0]), .oDone(done_v[0]),
        .iData(d0), .oBusy(busy_v[0]), .TXD(txd_v[0]));
    uart_word_txmod #(.BAUD_DIV(1157), .NBYTES(1), .STOP_BITS(2)) u1 (
        .CLOCK(CLOCK), .RESET(rst_v[1]), .iCall(call_v[1]), .oDone(done_v[1]),
        .iData(d1), .oBusy(busy_v[1]), .TXD(txd_v[1]));
    uart_word_txmod #(.BAUD_DIV(4), .NBYTES(2), .STOP_BITS(2)) u2 (
        .CLOCK(CLOCK), .RESET(rst_v[2]), .iCall(call_v[2]), .oDone(done_v[2]),
        .iData(d2), .oBusy(busy_v[2]), .TXD(txd_v[2]));
    uart_word_txmod #(.BAUD_DIV(4), .NBYTES(2), .STOP_BITS(1)) u3 (
        .CLOCK(CLOCK), .RESET(rst_v[3]), .iCall(call_v[3]), .oDone(done_v[3]),
        .iData(d3), .oBusy(busy_v[3]), .TXD(txd_v[3]));
    uart_word_txmod #(.BAUD_DIV(4), .NBYTES(1), .STOP_BITS(2)) u4 (
        .CLOCK(CLOCK), .RESET(rst_v[4]), .iCall(call_v[4]), .oDone(done_v[4]),
        .iData(d4), .oBusy(busy_v[4]), .TXD(txd_v[4]));

    // Captures one frame from the selected TXD, sampling every falling clock edge.
    task automatic decode_frame(input int baud, input int stop,
                                output logic [7:0] rx_byte, output logic [10:0] rx_bits,
                                output int start_cyc, output int low_run,
                                output bit stable, output bit stop_ok, output bit got);
        logic win;
        bit   still_low;
        int   n;
        rx_byte = '0; rx_bits = '1; start_cyc = 0; low_run = 0;
        stable = 1'b1; stop_ok = 1'b1; got = 1'b0; win = 1'b1;
        for (int w = 0; w < 40000; w++) begin
            @(negedge CLOCK);
            if (txd_m === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        start_cyc = cyc;
        n = (9 + stop) * baud;
        still_low = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge CLOCK);
            if (still_low && txd_m === 1'b0) low_run++;
            else still_low = 1'b0;
            if (i % baud == 0) win = txd_m;
            else if (txd_m !== win) stable = 1'b0;
            if (i % baud == baud / 2) rx_bits[i / baud] = txd_m;
        end
        rx_byte = rx_bits[8:1];
        for (int k = 9; k < 9 + stop; k++)
            if (rx_bits[k] !== 1'b1) stop_ok = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at_cyc, output bit got);
        got = 1'b0; at_cyc = 0;
        for (int w = 0; w < budget; w++) begin
            @(negedge CLOCK);
            if (done_v[sel] === 1'b1) begin
                got = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst_v = 5'h00;
        repeat (3) @(negedge CLOCK);
        n_total++;
        if (txd_v !== 5'h1F) $display("FAIL reset_txd got=%b want=11111", txd_v);
        else n_pass++;
        n_total++;
        if (busy_v !== 5'h00) $display("FAIL reset_busy got=%b want=00000", busy_v);
        else n_pass++;
        n_total++;
        if (done_v !== 5'h00) $display("FAIL reset_done got=%b want=00000", done_v);
        else n_pass++;
        rst_v = 5'h1F;
        repeat (4) @(negedge CLOCK);
        n_total++;
        if (txd_v !== 5'h1F || busy_v !== 5'h00)
            $display("FAIL idle_after_reset txd=%b busy=%b want txd=11111 busy=00000", txd_v, busy_v);
        else n_pass++;
    endtask

    // Runs one full word on the selected instance and scores every frame.
    task automatic run_word(input int baud, input int stop, input int nbytes, input int t_s,
                            input string tag, input logic [10:0] first_bits, input bit chk_first);
        logic [7:0]  rx_byte, e;
        logic [10:0] rx_bits;
        int start_cyc, low_run, at;
        bit stable, stop_ok, got;
        for (int b = 0; b < nbytes; b++) begin
            decode_frame(baud, stop, rx_byte, rx_bits, start_cyc, low_run, stable, stop_ok, got);
            n_total++;
            if (!got || exp_q.size() == 0) begin
                $display("FAIL %s_frame%0d_timeout got=%0d queued=%0d want frame", tag, b, got, exp_q.size());
                continue;
            end
            e = exp_q.pop_front();
            if (rx_byte !== e) $display("FAIL %s_byte%0d got=%h want=%h", tag, b, rx_byte, e);
            else n_pass++;
            n_total++;
            if (!stable || !stop_ok)
                $display("FAIL %s_frame%0d_shape stable=%0d stop_ok=%0d want 1 1", tag, b, stable, stop_ok);
            else n_pass++;
            if (b == 0) begin
                n_total++;
                if (start_cyc - t_s !== 2)
                    $display("FAIL %s_start_latency got=%0d want=2", tag, start_cyc - t_s);
                else n_pass++;
                if (chk_first) begin
                    n_total++;
                    if (rx_bits !== first_bits)
                        $display("FAIL %s_first_bits got=%b want=%b", tag, rx_bits, first_bits);
                    else n_pass++;
                end
            end
        end
        wait_done(200, at, got);
        call_v[sel] = 1'b0;
        n_total++;
        if (!got) $display("FAIL %s_done_timeout got=none want pulse", tag);
        else if (at - t_s !== 2 + nbytes * (9 + stop) * baud)
            $display("FAIL %s_done_time got=%0d want=%0d", tag, at - t_s, 2 + nbytes * (9 + stop) * baud);
        else n_pass++;
        n_total++;
        if (busy_v[sel] !== 1'b0) $display("FAIL %s_busy_at_done got=%b want=0", tag, busy_v[sel]);
        else n_pass++;
        @(negedge CLOCK);
        n_total++;
        if (done_v[sel] !== 1'b0) $display("FAIL %s_done_width got=%b want=0", tag, done_v[sel]);
        else n_pass++;
    endtask

    task automatic test_basic_word;
        int t_s, c0;
        sel = 3'd0;
        @(negedge CLOCK);
        d0 = 64'hAABBCCDDEEFF8899;
        for (int i = 7; i >= 0; i--) exp_q.push_back(d0[i*8 +: 8]);
        call_v[0] = 1'b1;
        t_s = cyc + 1;
        c0 = done_cnt[0];
        @(negedge CLOCK);
        n_total++;
        if (busy_v[0] !== 1'b1) $display("FAIL basic_busy got=%b want=1", busy_v[0]);
        else n_pass++;
        run_word(4, 2, 8, t_s, "basic", 11'b11101010100, 1'b1);
        repeat (5) @(negedge CLOCK);
        n_total++;
        if (done_cnt[0] - c0 !== 1) $display("FAIL basic_done_count got=%0d want=1", done_cnt[0] - c0);
        else n_pass++;
    endtask

    task automatic test_real_baud;
        logic [7:0]  rx_byte;
        logic [10:0] rx_bits;
        int t_s, start_cyc, low_run, at;
        bit stable, stop_ok, got;
        sel = 3'd1;
        @(negedge CLOCK);
        d1 = 8'h55;
        call_v[1] = 1'b1;
        t_s = cyc + 1;
        decode_frame(1157, 2, rx_byte, rx_bits, start_cyc, low_run, stable, stop_ok, got);
        n_total++;
        if (!got || rx_byte !== 8'h55) $display("FAIL real_byte got=%h want=55", rx_byte);
        else n_pass++;
        n_total++;
        if (low_run !== 1157) $display("FAIL real_start_len got=%0d want=1157", low_run);
        else n_pass++;
        n_total++;
        if (!stable) $display("FAIL real_bit_len stable=%0d want=1", stable);
        else n_pass++;
        wait_done(200, at, got);
        call_v[1] = 1'b0;
        n_total++;
        if (!got || at - t_s !== 12729) $display("FAIL real_done_time got=%0d want=12729", at - t_s);
        else n_pass++;
    endtask

    task automatic test_data_stability;
        int t_s;
        sel = 3'd2;
        @(negedge CLOCK);
        d2 = 16'h1234;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        call_v[2] = 1'b1;
        t_s = cyc + 1;
        @(negedge CLOCK);
        d2 = 16'hFFFF;
        run_word(4, 2, 2, t_s, "stable", 11'h7FF, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0]  rx_byte;
        logic [10:0] rx_bits;
        int t_s, td1, td2, start_cyc, low_run, c0;
        bit stable, stop_ok, got;
        sel = 3'd4;
        @(negedge CLOCK);
        d4 = 8'hA5;
        exp_q.push_back(8'hA5);
        call_v[4] = 1'b1;
        t_s = cyc + 1;
        c0 = done_cnt[4];
        decode_frame(4, 2, rx_byte, rx_bits, start_cyc, low_run, stable, stop_ok, got);
        n_total++;
        if (!got || rx_byte !== exp_q[0]) $display("FAIL b2b_byte0 got=%h want=%h", rx_byte, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        wait_done(200, td1, got);
        n_total++;
        if (!got || td1 - t_s !== 46) $display("FAIL b2b_done1_time got=%0d want=46", td1 - t_s);
        else n_pass++;
        d4 = 8'h3C;
        exp_q.push_back(8'h3C);
        decode_frame(4, 2, rx_byte, rx_bits, start_cyc, low_run, stable, stop_ok, got);
        // oDone cycle, then the IDLE sample cycle, then LOAD: start bit lands 4 clocks after oDone rises.
        n_total++;
        if (!got || start_cyc - td1 !== 4) $display("FAIL b2b_gap got=%0d want=4", start_cyc - td1);
        else n_pass++;
        n_total++;
        if (rx_byte !== exp_q[0]) $display("FAIL b2b_byte1 got=%h want=%h", rx_byte, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        wait_done(200, td2, got);
        call_v[4] = 1'b0;
        n_total++;
        if (!got || td2 - start_cyc !== 44) $display("FAIL b2b_done2_time got=%0d want=44", td2 - start_cyc);
        else n_pass++;
        repeat (8) @(negedge CLOCK);
        n_total++;
        if (done_cnt[4] - c0 !== 2) $display("FAIL b2b_done_count got=%0d want=2", done_cnt[4] - c0);
        else n_pass++;
        n_total++;
        if (busy_v[4] !== 1'b0 || txd_v[4] !== 1'b1)
            $display("FAIL b2b_idle busy=%b txd=%b want 0 1", busy_v[4], txd_v[4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0]  rx_byte;
        logic [10:0] rx_bits;
        int t_s, start_cyc, low_run, c0;
        bit stable, stop_ok, got;
        sel = 3'd0;
        @(negedge CLOCK);
        d0 = 64'h0123456789ABCDEF;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h23);
        call_v[0] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            decode_frame(4, 2, rx_byte, rx_bits, start_cyc, low_run, stable, stop_ok, got);
            n_total++;
            if (!got || rx_byte !== exp_q[0]) $display("FAIL rstmid_byte%0d got=%h want=%h", b, rx_byte, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
        end
        got = 1'b0;
        for (int w = 0; w < 100; w++) begin
            @(negedge CLOCK);
            if (txd_m === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        repeat (17) @(negedge CLOCK);
        // Frame bit 4 of byte 0x45 is data bit 3, a zero, so the reset must visibly lift the line.
        n_total++;
        if (!got || txd_v[0] !== 1'b0) $display("FAIL rstmid_pre got=%b want=0", txd_v[0]);
        else n_pass++;
        c0 = done_cnt[0];
        #2 rst_v[0] = 1'b0;
        call_v[0] = 1'b0;
        #1;
        n_total++;
        if (txd_v[0] !== 1'b1) $display("FAIL rstmid_async_txd got=%b want=1", txd_v[0]);
        else n_pass++;
        n_total++;
        if (busy_v[0] !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy_v[0]);
        else n_pass++;
        repeat (3) @(negedge CLOCK);
        rst_v[0] = 1'b1;
        repeat (60) @(negedge CLOCK);
        n_total++;
        if (done_cnt[0] !== c0 || txd_v[0] !== 1'b1)
            $display("FAIL rstmid_abandon done_pulses=%0d txd=%b want 0 1", done_cnt[0] - c0, txd_v[0]);
        else n_pass++;
        d0 = 64'hFEDCBA9876543210;
        for (int i = 7; i >= 0; i--) exp_q.push_back(d0[i*8 +: 8]);
        call_v[0] = 1'b1;
        t_s = cyc + 1;
        run_word(4, 2, 8, t_s, "rstmid_resend", 11'h7FF, 1'b0);
    endtask

    task automatic test_stop_bits;
        int t_s;
        sel = 3'd3;
        @(negedge CLOCK);
        d3 = 16'hC35A;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        call_v[3] = 1'b1;
        t_s = cyc + 1;
        run_word(4, 1, 2, t_s, "stop1", {2'b11, 8'hC3, 1'b0}, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_real_baud();
        test_data_stability();
        test_back_to_back();
        test_reset_mid_frame();
        test_stop_bits();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
